jtag_tap_sampled: RTL and testbench

Synthesizable JTAG TAP responder; the target-side end of the TCK/TMS/TDI/TRST/TDO link driven by the testbench JTAG bridge. It oversamples the JTAG pins on the system clock, runs the IEEE 1149.1 16-state TAP FSM and provides IDCODE, BYPASS and one USER data register. The USER register gives the SoC a 32-bit mailbox written and read over JTAG.

---
 rtl/jtag_tap_sampled_if.sv | 12 +
 rtl/jtag_tap_sampled.sv | 177 +++++++++++++++++
 tb/tb_jtag_tap_sampled.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_tap_sampled_if.sv
// JTAG pin bundle between the JTAG bridge (master) and the sampled TAP responder (slave).
interface jtag_tap_sampled_if;
  logic tck;
  logic tms;
  logic tdi;
  logic trst_n;
  logic tdo;
  logic tdo_oe;

  modport master (output tck, tms, tdi, trst_n, input tdo, tdo_oe);
  modport slave  (input tck, tms, tdi, trst_n, output tdo, tdo_oe);
endinterface

// File: rtl/jtag_tap_sampled.sv
// JTAG TAP responder oversampling TCK/TMS/TDI on clk_i: IDCODE, BYPASS and a USER mailbox DR.
// Define JTAG_TAP_TRST_EN to honour trst_n as a TAP-only reset.
module jtag_tap_sampled #(
  parameter int unsigned IR_WIDTH      = 5,
  parameter logic [31:0] IDCODE_VALUE  = 32'h249511C3,
  parameter int unsigned USER_DR_WIDTH = 32,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  jtag_tap_sampled_if.slave        jtag,
  output logic [3:0]               tap_state_o,
  input  logic [USER_DR_WIDTH-1:0] user_dr_i,
  output logic [USER_DR_WIDTH-1:0] user_dr_o,
  output logic                     user_dr_valid_o,
  output logic                     user_capture_o
);
  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(4);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE   = IR_WIDTH'(2'b01);

  tap_state_e state_q, state_d;
  logic [SYNC_STAGES-1:0][2:0] pin_sync_q;
  logic tck_s, tms_s, tdi_s, tck_q, tck_rise, tck_fall, tap_rst;
  logic [IR_WIDTH-1:0] ir_q, ir_sr_q;
  logic [31:0] id_sr_q;
  logic [USER_DR_WIDTH-1:0] user_sr_q;
  logic byp_q, sel_idcode, sel_user, dr_lsb;

  // TCK, TMS and TDI share one synchronizer chain so they are seen in the same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pin_sync_q <= '0;
      tck_q      <= 1'b0;
    end else begin
      pin_sync_q <= {pin_sync_q[SYNC_STAGES-2:0], {jtag.tdi, jtag.tms, jtag.tck}};
      tck_q      <= tck_s;
    end
  end

  assign tck_s = pin_sync_q[SYNC_STAGES-1][0];
  assign tms_s = pin_sync_q[SYNC_STAGES-1][1];
  assign tdi_s = pin_sync_q[SYNC_STAGES-1][2];

`ifdef JTAG_TAP_TRST_EN
  logic [SYNC_STAGES-1:0] trst_sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trst_sync_q <= '0;
    else         trst_sync_q <= {trst_sync_q[SYNC_STAGES-2:0], jtag.trst_n};
  end
  assign tap_rst = ~trst_sync_q[SYNC_STAGES-1];
`else
  logic unused_trst;
  assign unused_trst = jtag.trst_n;
  assign tap_rst     = 1'b0;
`endif

  assign tck_rise = tck_s & ~tck_q & ~tap_rst;
  assign tck_fall = ~tck_s & tck_q & ~tap_rst;

  assign sel_idcode  = (ir_q == INSTR_IDCODE);
  assign sel_user    = (ir_q == INSTR_USER);
  assign dr_lsb      = sel_idcode ? id_sr_q[0] : (sel_user ? user_sr_q[0] : byp_q);
  assign tap_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= TLR;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tap_rst) begin
      state_d = TLR;
    end else if (tck_rise) begin
      case (state_q)
        TLR:     state_d = tms_s ? TLR    : RTI;
        RTI:     state_d = tms_s ? SEL_DR : RTI;
        SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR:  state_d = tms_s ? UPD_DR : PAU_DR;
        PAU_DR:  state_d = tms_s ? EX2_DR : PAU_DR;
        EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
        UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
        SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
        CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR:  state_d = tms_s ? UPD_IR : PAU_IR;
        PAU_IR:  state_d = tms_s ? EX2_IR : PAU_IR;
        EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
        UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  // Shifts act in the current state; capture/update/TLR actions act on entry to their state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ir_q            <= INSTR_IDCODE;
      ir_sr_q         <= '0;
      id_sr_q         <= '0;
      user_sr_q       <= '0;
      byp_q           <= 1'b0;
      jtag.tdo        <= 1'b0;
      jtag.tdo_oe     <= 1'b0;
      user_dr_o       <= '0;
      user_dr_valid_o <= 1'b0;
      user_capture_o  <= 1'b0;
    end else begin
      user_dr_valid_o <= 1'b0;
      user_capture_o  <= 1'b0;
      if (tap_rst) begin
        ir_q        <= INSTR_IDCODE;
        ir_sr_q     <= '0;
        id_sr_q     <= '0;
        user_sr_q   <= '0;
        byp_q       <= 1'b0;
        jtag.tdo    <= 1'b0;
        jtag.tdo_oe <= 1'b0;
      end else if (tck_rise) begin
        if (state_q == SH_IR) ir_sr_q <= {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
        if (state_q == SH_DR) begin
          if (sel_idcode)    id_sr_q   <= {tdi_s, id_sr_q[31:1]};
          else if (sel_user) user_sr_q <= {tdi_s, user_sr_q[USER_DR_WIDTH-1:1]};
          else               byp_q     <= tdi_s;
        end
        case (state_d)
          TLR:    ir_q    <= INSTR_IDCODE;
          CAP_IR: ir_sr_q <= IR_CAPTURE;
          UPD_IR: ir_q    <= ir_sr_q;
          CAP_DR: begin
            if (sel_idcode) begin
              id_sr_q <= IDCODE_VALUE;
            end else if (sel_user) begin
              user_sr_q      <= user_dr_i;
              user_capture_o <= 1'b1;
            end else begin
              byp_q <= 1'b0;
            end
          end
          UPD_DR: begin
            if (sel_user) begin
              user_dr_o       <= user_sr_q;
              user_dr_valid_o <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (tck_fall) begin
        case (state_q)
          SH_IR: begin
            jtag.tdo    <= ir_sr_q[0];
            jtag.tdo_oe <= 1'b1;
          end
          SH_DR: begin
            jtag.tdo    <= dr_lsb;
            jtag.tdo_oe <= 1'b1;
          end
          default: begin
            jtag.tdo    <= 1'b0;
            jtag.tdo_oe <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled: IDCODE, BYPASS, IR capture, USER mailbox, resets.
module tb_jtag_tap_sampled;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  tap_state;
  logic [31:0] user_dr_i;
  logic [31:0] user_dr_o;
  logic        user_dr_valid;
  logic        user_capture;
  int cmp_cnt = 0;
  int err_cnt = 0;
  int valid_cnt = 0;
  int cap_cnt = 0;

  jtag_tap_sampled_if jtag();

  jtag_tap_sampled dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .jtag           (jtag),
    .tap_state_o    (tap_state),
    .user_dr_i      (user_dr_i),
    .user_dr_o      (user_dr_o),
    .user_dr_valid_o(user_dr_valid),
    .user_capture_o (user_capture)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (user_dr_valid) valid_cnt <= valid_cnt + 1;
    if (user_capture)  cap_cnt   <= cap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One TCK period: TDO/OE are sampled just before the rise, as a JTAG master would
  task automatic tclk(input logic tms, input logic tdi, output logic tdo, output logic oe);
    jtag.tms = tms;
    jtag.tdi = tdi;
    repeat (2) @(posedge clk); #1;
    tdo = jtag.tdo;
    oe  = jtag.tdo_oe;
    jtag.tck = 1'b1;
    repeat (6) @(posedge clk); #1;
    jtag.tck = 1'b0;
    repeat (6) @(posedge clk); #1;
  endtask

  task automatic tms_seq(input logic [7:0] bits, input int n);
    logic d, o;
    for (int i = 0; i < n; i++) tclk(bits[i], 1'b0, d, o);
  endtask

  task automatic shift_bits(input int n, input logic [63:0] din, input bit exit_last,
                            output logic [63:0] dout, output bit oe_all);
    logic b, o;
    dout   = '0;
    oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      tclk(exit_last && (i == n - 1), din[i], b, o);
      dout[i] = b;
      if (o !== 1'b1) oe_all = 1'b0;
    end
  endtask

  logic [63:0] dout;
  bit          oe_all;
  int          vs, cs;
  logic [31:0] y;
  logic [16:0] pat;
  logic        d, o;

  initial begin
    rst_n       = 1'b0;
    jtag.tck    = 1'b0;
    jtag.tms    = 1'b1;
    jtag.tdi    = 1'b0;
    jtag.trst_n = 1'b1;
    user_dr_i   = '0;
    repeat (4) @(posedge clk); #1;
    chk("rst_state", 64'(tap_state), 64'hF);
    chk("rst_tdo", 64'(jtag.tdo), 64'h0);
    chk("rst_oe", 64'(jtag.tdo_oe), 64'h0);
    chk("rst_user_dr", 64'(user_dr_o), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    // IDCODE scan after five TMS=1 clocks
    tms_seq(8'h1F, 5);
    chk("tlr_after_5", 64'(tap_state), 64'hF);
    tms_seq(8'h00, 1);
    chk("rti", 64'(tap_state), 64'hC);
    tms_seq(8'b001, 3);
    chk("shift_dr", 64'(tap_state), 64'h2);
    shift_bits(32, 64'h0, 1'b1, dout, oe_all);
    chk("idcode", dout, 64'h249511C3);
    chk("idcode_oe", 64'(oe_all), 64'h1);
    chk("ex1dr_oe", 64'(jtag.tdo_oe), 64'h0);
    tms_seq(8'b01, 2);

    // BYPASS: all-ones IR, 8'hA5 comes back one clock late behind a 0
    tms_seq(8'b0011, 4);
    shift_bits(5, 64'h1F, 1'b1, dout, oe_all);
    chk("ir_cap_ones", dout, 64'h01);
    tms_seq(8'b01, 2);
    tms_seq(8'b001, 3);
    shift_bits(9, 64'h0A5, 1'b1, dout, oe_all);
    chk("bypass", dout, 64'h14A);
    tms_seq(8'b01, 2);

    // IR capture pattern with zeros shifted in
    tms_seq(8'b0011, 4);
    shift_bits(5, 64'h00, 1'b1, dout, oe_all);
    chk("ir_cap_zeros", dout, 64'h01);
    chk("ir_oe", 64'(oe_all), 64'h1);
    tms_seq(8'b1, 1);
    chk("upd_ir", 64'(tap_state), 64'hD);
    tms_seq(8'b0, 1);

    // USER mailbox write then capture-readback
    tms_seq(8'b0011, 4);
    shift_bits(5, 64'h04, 1'b1, dout, oe_all);
    tms_seq(8'b01, 2);
    vs = valid_cnt;
    cs = cap_cnt;
    tms_seq(8'b001, 3);
    shift_bits(32, 64'hDEADBEEF, 1'b1, dout, oe_all);
    tms_seq(8'b1, 1);
    chk("user_write", 64'(user_dr_o), 64'hDEADBEEF);
    chk("valid_once", 64'(valid_cnt - vs), 64'h1);
    chk("capture_once_w", 64'(cap_cnt - cs), 64'h1);
    tms_seq(8'b0, 1);
    user_dr_i = 32'h12345678;
    cs = cap_cnt;
    tms_seq(8'b001, 3);
    shift_bits(32, 64'hDEADBEEF, 1'b1, dout, oe_all);
    chk("user_read", dout, 64'h12345678);
    chk("capture_once_r", 64'(cap_cnt - cs), 64'h1);
    tms_seq(8'b01, 2);

    // rst_ni mid Shift-DR under USER aborts the scan
    vs = valid_cnt;
    tms_seq(8'b001, 3);
    shift_bits(16, 64'hFFFF, 1'b0, dout, oe_all);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 64'(tap_state), 64'hF);
    chk("mid_rst_user_dr", 64'(user_dr_o), 64'h0);
    repeat (3) @(posedge clk); #1;
    chk("mid_rst_no_valid", 64'(valid_cnt - vs), 64'h0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    // TMS reset mid Shift-DR: the walk to TLR crosses Update-DR, so the captured
    // word and TDI bits are chosen to reassemble exactly the current mailbox value
    tms_seq(8'b0, 1);
    tms_seq(8'b0011, 4);
    shift_bits(5, 64'h04, 1'b1, dout, oe_all);
    tms_seq(8'b01, 2);
    y = 32'hDEADBEEF;
    user_dr_i = y;
    tms_seq(8'b001, 3);
    shift_bits(32, 64'(y), 1'b1, dout, oe_all);
    tms_seq(8'b01, 2);
    chk("user_setup", 64'(user_dr_o), 64'(y));
    user_dr_i = {y[14:0], 17'h0};
    pat = y[31:15];
    tms_seq(8'b001, 3);
    shift_bits(16, 64'(pat), 1'b0, dout, oe_all);
    tclk(1'b1, pat[16], d, o);
    tms_seq(8'h0F, 4);
    chk("tms_rst_state", 64'(tap_state), 64'hF);
    chk("tms_rst_user_dr", 64'(user_dr_o), 64'(y));
    tms_seq(8'b0, 1);
    tms_seq(8'b001, 3);
    shift_bits(32, 64'h0, 1'b1, dout, oe_all);
    chk("tms_rst_idcode", dout, 64'h249511C3);
    tms_seq(8'b01, 2);

`ifdef JTAG_TAP_TRST_EN
    tms_seq(8'b010011, 6);
    chk("pause_ir", 64'(tap_state), 64'hB);
    jtag.trst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("trst_state", 64'(tap_state), 64'hF);
    chk("trst_oe", 64'(jtag.tdo_oe), 64'h0);
    jtag.trst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    tms_seq(8'b0, 1);
    tms_seq(8'b001, 3);
    shift_bits(32, 64'h0, 1'b1, dout, oe_all);
    chk("trst_idcode", dout, 64'h249511C3);
    chk("trst_user_kept", 64'(user_dr_o), 64'(y));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
